// File: rtl/fighter_motion.sv
`default_nettype none
// ============================================================================
// Module   : fighter_motion
// Purpose  : Per-player walk/crouch/jump/knockback motion controller, one
//            update per frame_clk edge. Optional FIGHTER_AIR_CONTROL_EN
//            lets Left/Right steer while airborne.
// Revision : 1.0 - initial release
// ============================================================================
module fighter_motion #(
   parameter int         X_CENTER    = 40,
   parameter int         Y_GROUND    = 215,
   parameter int         X_MIN       = 10,
   parameter int         X_MAX       = 520,
   parameter int         WALK_STEP   = 2,
   parameter int         MIN_GAP     = 105,
   parameter int         JUMP_V0     = 12,
   parameter int         GRAVITY     = 1,
   parameter int         LAND_FRAMES = 2,
   parameter int         STUN_FRAMES = 8,
   parameter logic [7:0] KEY_LEFT    = 8'h04,
   parameter logic [7:0] KEY_RIGHT   = 8'h07,
   parameter logic [7:0] KEY_CROUCH  = 8'h16,
   parameter logic [7:0] KEY_JUMP    = 8'h1A
) (
   input  logic               frame_clk,
   input  logic               Reset,
   input  logic [7:0]         keycode_0,
   input  logic [7:0]         keycode_1,
   input  logic [7:0]         keycode_2,
   input  logic [7:0]         keycode_3,
   input  logic signed [10:0] XDist,
   input  logic signed [7:0]  Knockback,
   output logic [9:0]         X,
   output logic [9:0]         Y,
   output logic               Jump,
   output logic               Crouch,
   output logic               Left,
   output logic               Right,
   output logic               Stun,
   output logic               FacingRight,
   output logic [2:0]         State
);

   typedef enum logic [2:0] {
      ST_GROUND = 3'd0,
      ST_CROUCH = 3'd1,
      ST_AIR    = 3'd2,
      ST_LAND   = 3'd3,
      ST_STUN   = 3'd4
   } state_t;

   localparam logic signed [11:0] c_x_min    = 12'(X_MIN);
   localparam logic signed [11:0] c_x_max    = 12'(X_MAX);
   localparam logic signed [11:0] c_y_ground = 12'(Y_GROUND);
   localparam logic signed [11:0] c_step     = 12'(WALK_STEP);
   localparam logic signed [11:0] c_min_gap  = 12'(MIN_GAP);
   localparam logic signed [11:0] c_jump_v0  = 12'(JUMP_V0);
   localparam logic signed [11:0] c_gravity  = 12'(GRAVITY);
   localparam logic [7:0]         c_land     = 8'(LAND_FRAMES);
   localparam logic [7:0]         c_stun     = 8'(STUN_FRAMES);

   state_t             r_state, w_nxt_state;
   logic [9:0]         r_x, r_y, w_nxt_x, w_nxt_y;
   logic signed [11:0] r_yvel, w_nxt_yvel;
   logic signed [11:0] r_xvel, w_nxt_xvel;
   logic [7:0]         r_cnt, w_nxt_cnt;
   logic               r_armed, r_left, r_right, r_facing;
   logic               w_takeoff;

   logic               w_left_p, w_right_p, w_crouch_p, w_jump_p, w_knock;
   logic               w_fwd_right, w_near, w_ok_r, w_ok_l;
   logic signed [11:0] w_x, w_xdist, w_gap, w_walk, w_dx, w_kb, w_xsum;
   logic signed [11:0] w_yext, w_ysum;

   assign w_left_p   = (keycode_0 == KEY_LEFT)   || (keycode_1 == KEY_LEFT)   ||
                       (keycode_2 == KEY_LEFT)   || (keycode_3 == KEY_LEFT);
   assign w_right_p  = (keycode_0 == KEY_RIGHT)  || (keycode_1 == KEY_RIGHT)  ||
                       (keycode_2 == KEY_RIGHT)  || (keycode_3 == KEY_RIGHT);
   assign w_crouch_p = (keycode_0 == KEY_CROUCH) || (keycode_1 == KEY_CROUCH) ||
                       (keycode_2 == KEY_CROUCH) || (keycode_3 == KEY_CROUCH);
   assign w_jump_p   = (keycode_0 == KEY_JUMP)   || (keycode_1 == KEY_JUMP)   ||
                       (keycode_2 == KEY_JUMP)   || (keycode_3 == KEY_JUMP);

   assign w_x     = {2'b00, r_x};
   assign w_yext  = {2'b00, r_y};
   assign w_xdist = {XDist[10], XDist};
   assign w_kb    = {{4{Knockback[7]}}, Knockback};
   assign w_knock = (Knockback != 8'sd0);

   // Forward means toward the opponent; the gap rule only blocks forward steps.
   assign w_fwd_right = ~XDist[10];
   assign w_gap       = w_xdist[11] ? -w_xdist : w_xdist;
   assign w_near      = (w_gap <= c_min_gap);
   assign w_ok_r      = w_right_p & ~w_left_p & ~(w_fwd_right & w_near) & (w_x < c_x_max);
   assign w_ok_l      = w_left_p & ~w_right_p & ~(~w_fwd_right & w_near) & (w_x > c_x_min);
   assign w_walk      = w_ok_r ? c_step : (w_ok_l ? -c_step : 12'sd0);

   assign w_ysum = w_yext + r_yvel;

   always_comb begin
      w_nxt_state = r_state;
      w_nxt_y     = r_y;
      w_nxt_yvel  = r_yvel;
      w_nxt_xvel  = r_xvel;
      w_nxt_cnt   = r_cnt;
      w_dx        = 12'sd0;
      w_takeoff   = 1'b0;

      case (r_state)
         ST_GROUND: begin
            if (w_jump_p && r_armed) begin
               w_nxt_state = ST_AIR;
               w_nxt_yvel  = -c_jump_v0;
               w_nxt_xvel  = w_walk;
               w_takeoff   = 1'b1;
            end else if (w_crouch_p) begin
               w_nxt_state = ST_CROUCH;
            end else begin
               w_dx = w_walk;
            end
         end
         ST_CROUCH: begin
            if (w_jump_p && r_armed) begin
               w_nxt_state = ST_AIR;
               w_nxt_yvel  = -c_jump_v0;
               w_nxt_xvel  = w_walk;
               w_takeoff   = 1'b1;
            end else if (!w_crouch_p) begin
               w_nxt_state = ST_GROUND;
            end
         end
         ST_AIR: begin
`ifdef FIGHTER_AIR_CONTROL_EN
            w_dx = w_walk;
`else
            w_dx = r_xvel;
`endif
            if (w_ysum >= c_y_ground) begin
               w_nxt_y    = c_y_ground[9:0];
               w_nxt_yvel = 12'sd0;
               w_nxt_cnt  = c_land;
               w_nxt_state = (c_land == 8'd0) ? ST_GROUND : ST_LAND;
            end else begin
               w_nxt_y    = w_ysum[9:0];
               w_nxt_yvel = r_yvel + c_gravity;
            end
         end
         ST_LAND, ST_STUN: begin
            if (r_cnt <= 8'd1) begin
               w_nxt_state = ST_GROUND;
               w_nxt_cnt   = 8'd0;
            end else begin
               w_nxt_cnt = r_cnt - 8'd1;
            end
         end
         default: w_nxt_state = ST_GROUND;
      endcase

      // Knockback stuns unless we are mid-flight; it also wins over a takeoff or landing.
      if (w_knock && (r_state != ST_AIR || w_nxt_state != ST_AIR)) begin
         w_nxt_state = ST_STUN;
         w_nxt_cnt   = c_stun;
         w_nxt_y     = c_y_ground[9:0];
         w_nxt_yvel  = 12'sd0;
         w_takeoff   = 1'b0;
      end

      w_xsum = w_x + w_dx + w_kb;
      if (w_xsum < c_x_min) begin
         w_nxt_x = c_x_min[9:0];
      end else if (w_xsum > c_x_max) begin
         w_nxt_x = c_x_max[9:0];
      end else begin
         w_nxt_x = w_xsum[9:0];
      end
   end

   always_ff @(posedge frame_clk) begin
      if (!Reset) begin
         r_state  <= ST_GROUND;
         r_x      <= 10'(X_CENTER);
         r_y      <= 10'(Y_GROUND);
         r_yvel   <= 12'sd0;
         r_xvel   <= 12'sd0;
         r_cnt    <= 8'd0;
         r_armed  <= 1'b1;
         r_left   <= 1'b0;
         r_right  <= 1'b0;
         r_facing <= 1'b1;
      end else begin
         r_state  <= w_nxt_state;
         r_x      <= w_nxt_x;
         r_y      <= w_nxt_y;
         r_yvel   <= w_nxt_yvel;
         r_xvel   <= w_nxt_xvel;
         r_cnt    <= w_nxt_cnt;
         r_armed  <= ~w_jump_p | (r_armed & ~w_takeoff);
         r_left   <= (w_dx < 12'sd0);
         r_right  <= (w_dx > 12'sd0);
         r_facing <= ~XDist[10];
      end
   end

   assign X           = r_x;
   assign Y           = r_y;
   assign State       = r_state;
   assign Jump        = (r_state == ST_AIR);
   assign Crouch      = (r_state == ST_CROUCH);
   assign Stun        = (r_state == ST_STUN);
   assign Left        = r_left;
   assign Right       = r_right;
   assign FacingRight = r_facing;

endmodule
`default_nettype wire

// File: tb/tb_fighter_motion.sv
`default_nettype none
// tb_fighter_motion: directed scenarios plus randomized frames, each checked
// against a frame-level model built from the movement rules.
module tb_fighter_motion;
   localparam int XC = 40, YG = 215, XMIN = 10, XMAX = 520, STEP = 2, GAP = 105;
   localparam int V0 = 12, G = 1, LANDF = 2, STUNF = 8;

   logic               frame_clk = 1'b0;
   logic               reset_n;
   logic [7:0]         kc [4];
   logic signed [10:0] xdist;
   logic signed [7:0]  kb;
   logic [9:0]         X, Y;
   logic               Jump, Crouch, Left, Right, Stun, FacingRight;
   logic [2:0]         State;

   int n_cmp = 0;
   int n_fail = 0;

   // model state: m_k counts airborne frames since takeoff
   int m_x, m_y, m_st, m_k, m_vx, m_cnt;
   bit m_armed, m_l, m_r, m_face;

   always #5 frame_clk = ~frame_clk;

   fighter_motion dut (
      .frame_clk  (frame_clk),
      .Reset      (reset_n),
      .keycode_0  (kc[0]),
      .keycode_1  (kc[1]),
      .keycode_2  (kc[2]),
      .keycode_3  (kc[3]),
      .XDist      (xdist),
      .Knockback  (kb),
      .X          (X),
      .Y          (Y),
      .Jump       (Jump),
      .Crouch     (Crouch),
      .Left       (Left),
      .Right      (Right),
      .Stun       (Stun),
      .FacingRight(FacingRight),
      .State      (State)
   );

   function automatic bit held(input logic [7:0] k);
      return (kc[0] == k) || (kc[1] == k) || (kc[2] == k) || (kc[3] == k);
   endfunction

   function automatic logic [28:0] dut_vec();
      return {X, Y, Jump, Crouch, Left, Right, Stun, FacingRight, State};
   endfunction

   function automatic logic [28:0] model_vec();
      return {10'(m_x), 10'(m_y), (m_st == 2), (m_st == 1), m_l, m_r, (m_st == 4), m_face, 3'(m_st)};
   endfunction

   task automatic model_step();
      bit pl, pr, pc, pj, lands, took;
      int walk, dx, kbi, xd, h, nxt, nx;
      if (!reset_n) begin
         m_x = XC; m_y = YG; m_st = 0; m_k = 0; m_vx = 0; m_cnt = 0;
         m_armed = 1; m_l = 0; m_r = 0; m_face = 1;
         return;
      end
      pl = held(8'h04); pr = held(8'h07); pc = held(8'h16); pj = held(8'h1A);
      xd = int'(xdist);
      kbi = int'(kb);
      walk = 0;
      if (pr && !pl) walk = STEP;
      else if (pl && !pr) walk = -STEP;
      if (walk != 0 && ((walk > 0) == (xd >= 0)) && ((xd < 0 ? -xd : xd) <= GAP)) walk = 0;
      if ((walk > 0 && m_x >= XMAX) || (walk < 0 && m_x <= XMIN)) walk = 0;
      dx = 0; took = 0; lands = 0; nxt = m_st;
      case (m_st)
         0: if (pj && m_armed) took = 1; else if (pc) nxt = 1; else dx = walk;
         1: if (pj && m_armed) took = 1; else if (!pc) nxt = 0;
         2: begin
`ifdef FIGHTER_AIR_CONTROL_EN
            dx = walk;
`else
            dx = m_vx;
`endif
            h = V0 * (m_k + 1) - G * (m_k + 1) * m_k / 2;
            if (h <= 0) lands = 1;
            else begin m_k = m_k + 1; m_y = YG - h; end
         end
         default: if (m_cnt <= 1) begin nxt = 0; m_cnt = 0; end else m_cnt = m_cnt - 1;
      endcase
      if (took) begin nxt = 2; m_k = 0; m_vx = walk; end
      if (lands) begin m_y = YG; nxt = (LANDF == 0) ? 0 : 3; m_cnt = LANDF; end
      if (kbi != 0 && !(m_st == 2 && !lands)) begin
         nxt = 4; m_cnt = STUNF; took = 0; m_y = YG;
      end
      if (!pj) m_armed = 1;
      else if (took) m_armed = 0;
      nx = m_x + dx + kbi;
      m_x = (nx < XMIN) ? XMIN : (nx > XMAX) ? XMAX : nx;
      m_l = (dx < 0); m_r = (dx > 0);
      m_face = (xd >= 0);
      m_st = nxt;
   endtask

   task automatic tick();
      @(posedge frame_clk);
      model_step();
      #1;
   endtask

   task automatic set_keys(input logic [7:0] a, input logic [7:0] b);
      kc[0] = a; kc[1] = b; kc[2] = 8'h00; kc[3] = 8'h00;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; set_keys(8'h07, 8'h1A); xdist = -11'sd300; kb = 8'sd5;
      tick(); tick();
      n_cmp++;
      if (dut_vec() !== {10'd40, 10'd215, 6'b000001, 3'd0}) begin
         n_fail++; $display("FAIL reset_state: got %h want %h", dut_vec(), {10'd40, 10'd215, 6'b000001, 3'd0});
      end
      reset_n = 1'b1; set_keys(8'h00, 8'h00); xdist = 11'sd300; kb = 8'sd0;
      tick();
      n_cmp++;
      if (dut_vec() !== {10'd40, 10'd215, 6'b000001, 3'd0}) begin
         n_fail++; $display("FAIL reset_idle: got %h want %h", dut_vec(), {10'd40, 10'd215, 6'b000001, 3'd0});
      end
   endtask

   task automatic test_walk();
      set_keys(8'h07, 8'h07);
      for (int i = 0; i < 10; i++) begin
         tick();
         n_cmp++;
         if (dut_vec() !== model_vec()) begin
            n_fail++; $display("FAIL walk_model: got %h want %h", dut_vec(), model_vec());
         end
      end
      n_cmp++;
      if (X !== 10'd60 || Right !== 1'b1) begin
         n_fail++; $display("FAIL walk_right: X=%0d Right=%b want X=60 Right=1", X, Right);
      end
      xdist = 11'sd100;
      tick(); tick();
      n_cmp++;
      if (X !== 10'd60 || Right !== 1'b0) begin
         n_fail++; $display("FAIL gap_block: X=%0d Right=%b want X=60 Right=0", X, Right);
      end
      set_keys(8'h00, 8'h00); xdist = 11'sd300;
      tick();
   endtask

   task automatic test_jump();
      int jcnt, apex, lcnt;
      jcnt = 0; apex = 1023; lcnt = 0;
      set_keys(8'h1A, 8'h00);
      tick();
      set_keys(8'h00, 8'h00);
      for (int i = 0; i < 40 && Jump === 1'b1; i++) begin
         jcnt++;
         if (int'(Y) < apex) apex = int'(Y);
         n_cmp++;
         if (dut_vec() !== model_vec()) begin
            n_fail++; $display("FAIL jump_model: got %h want %h", dut_vec(), model_vec());
         end
         tick();
      end
      n_cmp++;
      if (jcnt != 25 || apex != 137 || Y !== 10'd215) begin
         n_fail++; $display("FAIL jump_arc: frames=%0d apex=%0d Y=%0d want 25/137/215", jcnt, apex, Y);
      end
      for (int i = 0; i < 10 && State === 3'd3; i++) begin
         lcnt++;
         tick();
      end
      n_cmp++;
      if (lcnt != 2 || State !== 3'd0) begin
         n_fail++; $display("FAIL land_lag: land_frames=%0d State=%0d want 2/0", lcnt, State);
      end
   endtask

   task automatic test_hold_jump();
      int rises;
      logic prev;
      rises = 0; prev = Jump;
      set_keys(8'h1A, 8'h00);
      for (int i = 0; i < 60; i++) begin
         tick();
         if (Jump === 1'b1 && prev !== 1'b1) rises++;
         prev = Jump;
         n_cmp++;
         if (dut_vec() !== model_vec()) begin
            n_fail++; $display("FAIL hold_model: got %h want %h", dut_vec(), model_vec());
         end
      end
      n_cmp++;
      if (rises != 1) begin
         n_fail++; $display("FAIL hold_single: takeoffs=%0d want 1", rises);
      end
      set_keys(8'h00, 8'h00); tick();
      set_keys(8'h1A, 8'h00); tick();
      n_cmp++;
      if (Jump !== 1'b1 || State !== 3'd2) begin
         n_fail++; $display("FAIL rearm: Jump=%b State=%0d want 1/2", Jump, State);
      end
      set_keys(8'h00, 8'h00);
      for (int i = 0; i < 60 && State !== 3'd0; i++) tick();
      n_cmp++;
      if (State !== 3'd0) begin
         n_fail++; $display("FAIL rearm_land: State=%0d want 0", State);
      end
   endtask

   task automatic test_cancel_crouch();
      logic [9:0] x0;
      x0 = X;
      set_keys(8'h04, 8'h07);
      for (int i = 0; i < 3; i++) tick();
      n_cmp++;
      if (X !== x0 || Left !== 1'b0 || Right !== 1'b0) begin
         n_fail++; $display("FAIL lr_cancel: X=%0d L=%b R=%b want X=%0d L=0 R=0", X, Left, Right, x0);
      end
      set_keys(8'h16, 8'h00); tick();
      n_cmp++;
      if (State !== 3'd1 || Crouch !== 1'b1) begin
         n_fail++; $display("FAIL crouch: State=%0d Crouch=%b want 1/1", State, Crouch);
      end
      set_keys(8'h16, 8'h1A); tick();
      n_cmp++;
      if (State !== 3'd2 || Crouch !== 1'b0) begin
         n_fail++; $display("FAIL crouch_jump: State=%0d Crouch=%b want 2/0", State, Crouch);
      end
      set_keys(8'h00, 8'h00);
      for (int i = 0; i < 60 && State !== 3'd0; i++) tick();
      n_cmp++;
      if (dut_vec() !== model_vec()) begin
         n_fail++; $display("FAIL crouch_land: got %h want %h", dut_vec(), model_vec());
      end
   endtask

   task automatic test_knock_wall();
      int scnt;
      bit xbad;
      scnt = 0; xbad = 0;
      xdist = 11'sd300;
      set_keys(8'h04, 8'h00);
      for (int i = 0; i < 24; i++) tick();
      n_cmp++;
      if (X !== 10'd12) begin
         n_fail++; $display("FAIL back_walk: X=%0d want 12", X);
      end
      set_keys(8'h00, 8'h00); kb = -8'sd8;
      tick();
      kb = 8'sd0;
      n_cmp++;
      if (X !== 10'd10 || State !== 3'd4 || Stun !== 1'b1) begin
         n_fail++; $display("FAIL knock_clamp: X=%0d State=%0d Stun=%b want 10/4/1", X, State, Stun);
      end
      set_keys(8'h07, 8'h1A);
      for (int i = 0; i < 20 && Stun === 1'b1; i++) begin
         scnt++;
         if (X !== 10'd10) xbad = 1;
         tick();
      end
      n_cmp++;
      if (scnt != 8 || xbad || X !== 10'd10 || State !== 3'd0) begin
         n_fail++; $display("FAIL stun_len: frames=%0d xmoved=%0d X=%0d State=%0d want 8/0/10/0", scnt, xbad, X, State);
      end
      set_keys(8'h00, 8'h00); tick();
   endtask

   function automatic logic [7:0] pick_key();
      case ($urandom_range(0, 7))
         0: return 8'h04;
         1: return 8'h07;
         2: return 8'h16;
         3: return 8'h1A;
         4: return 8'($urandom);
         default: return 8'h00;
      endcase
   endfunction

   task automatic test_random();
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 3) == 0)
            for (int k = 0; k < 4; k++) kc[k] = pick_key();
         if ($urandom_range(0, 7) == 0)
            xdist = 11'(int'($urandom_range(0, 700)) - 350);
         kb = ($urandom_range(0, 11) == 0) ? 8'(int'($urandom_range(0, 80)) - 40) : 8'sd0;
         reset_n = ($urandom_range(0, 299) != 0);
         tick();
         n_cmp++;
         if (dut_vec() !== model_vec()) begin
            n_fail++; $display("FAIL random frame %0d: got %h want %h", i, dut_vec(), model_vec());
         end
      end
      reset_n = 1'b1; kb = 8'sd0;
   endtask

   initial begin
      reset_n = 1'b0; set_keys(8'h00, 8'h00); xdist = 11'sd0; kb = 8'sd0;
      test_reset();
      test_walk();
      test_jump();
      test_hold_jump();
      test_cancel_crouch();
      test_knock_wall();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end
endmodule
`default_nettype wire

// File: doc/fighter_motion.md
Name: fighter_motion

Overview:
Per-player movement controller for the fighting game: decodes four USB keycodes into walk, crouch and jump actions, and integrates position once per frame. Includes an internal jump/gravity state machine, landing lag, knockback with hit-stun, wall clamping and opponent-gap blocking. Parametrised key map and physics, so one module serves both players. Outputs drive the sprite renderer and the hit/collision logic.

Parameters:
X_CENTER, 40, reset X position (pixels)
Y_GROUND, 215, ground Y position; also the reset Y position
X_MIN, 10, left wall; X never below this value
X_MAX, 520, right wall; X never above this value
WALK_STEP, 2, pixels per frame while walking
MIN_GAP, 105, minimum |XDist|; forward walk is blocked when |XDist| <= MIN_GAP
JUMP_V0, 12, takeoff speed (pixels per frame, upward)
GRAVITY, 1, added to vertical velocity each airborne frame
LAND_FRAMES, 2, frames of landing lag
STUN_FRAMES, 8, frames of hit-stun after grounded knockback
KEY_LEFT/KEY_RIGHT/KEY_CROUCH/KEY_JUMP, 8'h04/8'h07/8'h16/8'h1A, keycodes for each action

Ports:
frame_clk  in  1  frame clock; one rising edge per frame
Reset  in  1  synchronous, active-low reset
keycode_0..keycode_3  in  8 each  currently held keys; 8'h00 means none
XDist  in  11 signed  opponent X minus own X
Knockback  in  8 signed  horizontal displacement for this frame; 0 means none
X  out  10  position; reset value X_CENTER
Y  out  10  position; reset value Y_GROUND
Jump  out  1  airborne; reset 0
Crouch, Left, Right  out  1 each  action flags; reset 0
Stun  out  1  in hit-stun; reset 0
FacingRight  out  1  1 when XDist >= 0; reset 1
State  out  3  GROUND=0, CROUCH=1, AIR=2, LAND=3, STUN=4; reset 0

Behaviour:
- All logic is clocked on frame_clk. When Reset=0 at a rising edge, every output takes its reset value, velocity is cleared, counters are cleared and the jump-armed flag is set to 1.
- Key decode: an action is pressed when any keycode_i equals its KEY_* parameter. Duplicate keycodes are harmless.
- Latency: outputs reflect the inputs sampled at the same edge. One frame of latency.
- Internal arithmetic is 12-bit signed. The final X is clamped to [X_MIN, X_MAX]. Y never goes below Y_GROUND (larger value) after landing.
- Walking: Left and Right pressed together cancel each other (no motion, both flags 0).
  - Forward is the sign of XDist.
  - A forward step is suppressed, with its flag held at 0, when |XDist| <= MIN_GAP.
  - A backward step is suppressed at the wall.
- GROUND:
  - Jump pressed and armed: go to AIR, y_vel = -JUMP_V0, clear armed.
  - Otherwise Crouch pressed: go to CROUCH.
  - Otherwise walk by ±WALK_STEP.
  - Jump has priority over crouch.
- CROUCH: Crouch=1, no walking. Return to GROUND the frame after the crouch key is released. Jump pressed and armed takes priority and goes to AIR.
- AIR:
  - Each frame: if Y + y_vel >= Y_GROUND, then Y = Y_GROUND, y_vel = 0, go to LAND with counter = LAND_FRAMES. Otherwise Y += y_vel and y_vel += GRAVITY.
  - Jump=1 for the whole state.
  - Horizontal velocity is latched at takeoff (see optional feature).
- LAND: no movement. The counter decrements each frame; go to GROUND when it reaches 0. If LAND_FRAMES=0, skip LAND entirely.
- Armed flag: set on any frame where the jump key is not pressed. Holding the jump key never re-jumps.
- Knockback != 0:
  - Always applied: X += Knockback, then clamp.
  - In GROUND, CROUCH or LAND: go to STUN with counter = STUN_FRAMES, cancelling LAND.
  - In AIR: applied with no state change.
  - In STUN: applied and the counter reloads.
- STUN: Stun=1, keys ignored, no walking. Go to GROUND when the counter reaches 0.
- Simultaneous events:
  - Knockback and walk in the same frame: both displacements are summed before the clamp.
  - Knockback on the landing frame: state goes to STUN; Y = Y_GROUND.
- Reset mid-jump: Y returns to Y_GROUND and State to GROUND at that edge.

Optional Feature:
FIGHTER_AIR_CONTROL_EN
- Defined: while in AIR, Left/Right steer with WALK_STEP each frame, under the same gap and wall rules as walking.
- Undefined: the X velocity latched at takeoff (±WALK_STEP or 0) is applied every AIR frame, and key changes have no effect until landing.

Test Plan:
- Reset=0 for 2 frames, then Reset=1 with no keys → X=40, Y=215, State=0, all flags 0, FacingRight=1.
- XDist=300, hold 8'h07 for 10 frames → X=60, Right=1; then set XDist=100 → X holds at 60, Right=0.
- Tap 8'h1A for 1 frame → Jump=1 for 25 frames, apex Y=137, back at Y=215, then State=3 for 2 frames, then State=0.
- Hold 8'h1A for 60 frames → exactly one jump; release for 1 frame and press again → second jump starts.
- X=12 on ground, Knockback=-8 for 1 frame → X=10 (clamped), State=4, Stun=1 for 8 frames; keys ignored during stun.
- Keys 8'h04 and 8'h07 held together → X unchanged, Left=0, Right=0. Crouch held with jump pressed → AIR is entered.
